// File: rtl/ncl_sync_tx.sv
// ncl_sync_tx: synchronous-to-NCL boundary transmitter.
// Each accepted single-rail word leaves as a dual-rail DATA wavefront, then NULL, paced by ko.
module ncl_sync_tx #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TO_CYCLES   = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             ko,
    output logic [WIDTH-1:0] rail1,
    output logic [WIDTH-1:0] rail0,
    output logic             busy,
    output logic             err,
    output logic [15:0]      tx_count
);

    // state   | meaning
    // ST_RFD  | rails NULL, accepting a word while ko_s is high
    // ST_DATA | DATA wavefront driven, waiting for ko_s low
    // ST_NULL | NULL wavefront driven, waiting for ko_s high
    typedef enum logic [1:0] {
        ST_RFD  = 2'd0,
        ST_DATA = 2'd1,
        ST_NULL = 2'd2
    } state_t;

    localparam logic [15:0] TO_W = 16'(TO_CYCLES);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ko_sync_q, ko_sync_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic [15:0]            wait_q, wait_d;
    logic                   err_q, err_d;
    logic [15:0]            tx_count_q, tx_count_d;
    logic [WIDTH-1:0]       rail1_q, rail1_d;
    logic [WIDTH-1:0]       rail0_q, rail0_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;
    logic                   ko_s;

    assign ko_s = ko_sync_q[SYNC_STAGES-1];

    always_comb begin
        ko_sync_d  = {ko_sync_q[SYNC_STAGES-2:0], ko};
        state_d    = state_q;
        data_d     = data_q;
        wait_d     = wait_q;
        err_d      = err_q;
        tx_count_d = tx_count_q;

        case (state_q)
            ST_RFD: begin
                wait_d = '0;
                if (in_valid && in_ready_q) begin
                    data_d  = in_data;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!ko_s) begin
                    state_d    = ST_NULL;
                    wait_d     = '0;
                    tx_count_d = tx_count_q + 16'd1;
                end else if (wait_q != TO_W) begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ST_NULL: begin
                if (ko_s) begin
                    state_d = ST_RFD;
                    wait_d  = '0;
                end else if (wait_q != TO_W) begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_RFD;
                wait_d  = '0;
            end
        endcase

        err_d = err_q | (wait_d == TO_W);

        // Outputs are registered from next-state so they line up with the state they describe;
        // in_ready looks one sync stage ahead so the registered flag equals ko_s while in RFD.
        rail1_d    = (state_d == ST_DATA) ? data_d  : '0;
        rail0_d    = (state_d == ST_DATA) ? ~data_d : '0;
        busy_d     = (state_d != ST_RFD);
        in_ready_d = (state_d == ST_RFD) && ko_sync_d[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ko_sync_q  <= '0;
            state_q    <= ST_RFD;
            data_q     <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
            tx_count_q <= '0;
            rail1_q    <= '0;
            rail0_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ko_sync_q  <= ko_sync_d;
            state_q    <= state_d;
            data_q     <= data_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            tx_count_q <= tx_count_d;
            rail1_q    <= rail1_d;
            rail0_q    <= rail0_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready = in_ready_q;
    assign rail1    = rail1_q;
    assign rail0    = rail0_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign tx_count = tx_count_q;

endmodule
